mem2serial: RTL and testbench



---
 rtl/mem2serial.sv | 69 ++++++
 tb/tb_mem2serial.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem2serial.sv
// Pops one 48-bit capture record from the FIFO and sends it to the UART as six bytes, MSB first.
// The first byte strobe is 2 cycles after the pop; each byte waits on uart_ready, then holds off one cycle.
module mem2serial (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_empty,
  output logic        read_clock_enable,
  input  logic [47:0] read_data,
  output logic        uart_clock_enable,
  input  logic        uart_ready,
  output logic [7:0]  uart_data
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, HOLD} state_t;

  state_t      state_q, state_d;
  logic [47:0] hold_q, hold_d;
  logic [2:0]  cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    hold_d            = hold_q;
    cnt_d             = cnt_q;
    read_clock_enable = 1'b0;
    uart_clock_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (!read_empty && !reset) begin
          read_clock_enable = 1'b1;
          state_d           = LOAD;
        end
      end
      LOAD: begin
        hold_d  = read_data;
        cnt_d   = 3'd0;
        state_d = SEND;
      end
      SEND: begin
        if (uart_ready && !reset) begin
          uart_clock_enable = 1'b1;
          hold_d            = {hold_q[39:0], 8'h00};
          cnt_d             = cnt_q + 3'd1;
          state_d           = HOLD;
        end
      end
      // Holdoff cycle: a UART that drops ready one cycle late cannot trigger a repeat send.
      HOLD: begin
        state_d = (cnt_q < 3'd6) ? SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The top byte of the holding register is the byte being offered, so uart_data is a flop output.
  assign uart_data = hold_q[47:40];

endmodule

// File: tb/tb_mem2serial.sv
// Randomized bench for mem2serial: a FIFO model feeds records, and a byte-queue model predicts every strobe and byte.
module tb_mem2serial;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read_empty = 1'b1;
  logic        read_clock_enable;
  logic [47:0] read_data = '0;
  logic        uart_clock_enable;
  logic        uart_ready = 1'b0;
  logic [7:0]  uart_data;

  mem2serial dut (
    .clock             (clock),
    .reset             (reset),
    .read_empty        (read_empty),
    .read_clock_enable (read_clock_enable),
    .read_data         (read_data),
    .uart_clock_enable (uart_clock_enable),
    .uart_ready        (uart_ready),
    .uart_data         (uart_data)
  );

  always #5 clock = ~clock;

  logic [47:0] fifo[$];
  logic [7:0]  expq[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mode = 0;
  int busy = 0;
  int sent = 0;
  int earliest = 0;
  int idle_from = 0;
  bit frame = 1'b0;
  bit rst_prev = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [47:0] rand48();
    logic [47:0] w;
    w = {16'($urandom), 32'($urandom)};
    return w;
  endfunction

  // One clock cycle: drive inputs, sample at negedge, compare with the model, advance the model.
  task automatic cycle();
    logic        s_rce;
    logic        s_uce;
    logic [7:0]  s_ud;
    bit          exp_pop;
    bit          exp_uce;
    logic [47:0] w;
    read_empty = (fifo.size() == 0);
    case (mode)
      0:       uart_ready = 1'b0;
      1:       uart_ready = 1'b1;
      2:       uart_ready = (busy == 0);
      default: uart_ready = (busy == 0) && ($urandom_range(0, 3) != 0);
    endcase
    @(negedge clock);
    s_rce = read_clock_enable;
    s_uce = uart_clock_enable;
    s_ud  = uart_data;
    exp_pop = !reset && !frame && (cyc >= idle_from) && !read_empty;
    exp_uce = !reset && frame && (expq.size() > 0) && (cyc >= earliest) && uart_ready;
    check("read_strobe", 64'(s_rce), 64'(exp_pop));
    check("uart_strobe", 64'(s_uce), 64'(exp_uce));
    if (!reset && frame && (expq.size() > 0) && (cyc >= earliest))
      check("uart_data", 64'(s_ud), 64'(expq[0]));
    if (rst_prev)
      check("reset_data", 64'(s_ud), 64'd0);
    w = (fifo.size() > 0) ? fifo[0] : 48'd0;
    if (reset) begin
      frame = 1'b0;
      expq.delete();
      idle_from = cyc + 1;
    end else begin
      if (exp_pop) begin
        frame = 1'b1;
        earliest = cyc + 2;
        for (int i = 5; i >= 0; i--) expq.push_back(w[i*8 +: 8]);
      end
      if (exp_uce) begin
        void'(expq.pop_front());
        sent++;
        earliest = cyc + 2;
        if (expq.size() == 0) begin
          frame = 1'b0;
          idle_from = cyc + 2;
        end
      end
    end
    rst_prev = reset;
    @(posedge clock);
    #1;
    if (s_rce && fifo.size() > 0) read_data = fifo.pop_front();
    if (s_uce) busy = (mode == 2) ? 5 : $urandom_range(1, 4);
    else if (busy > 0) busy--;
    cyc++;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((fifo.size() > 0 || frame) && n < limit) begin
      cycle();
      n++;
    end
    check("drain_done", 64'(fifo.size() == 0 && !frame), 64'd1);
  endtask

  initial begin
    int s0;
    int n;
    fifo.push_back(48'h00123456789a);
    fifo.push_back(rand48());
    mode = 0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    repeat (2) cycle();
    reset = 1'b0;

    // Word is fetched even while the UART is busy, but nothing is sent.
    repeat (20) cycle();
    check("frame_pending", 64'(expq.size()), 64'd6);

    mode = 1;
    drain(100);

    repeat (50) cycle();

    mode = 2;
    repeat (3) fifo.push_back(rand48());
    drain(500);

    // Reset after the third byte discards the rest of the record.
    mode = 1;
    fifo.push_back(rand48());
    fifo.push_back(rand48());
    s0 = sent;
    n = 0;
    while ((sent - s0) < 3 && n < 100) begin
      cycle();
      n++;
    end
    check("third_byte_reached", 64'(sent - s0), 64'd3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drain(100);

    mode = 3;
    for (int k = 0; k < 8; k++) begin
      fifo.push_back(rand48());
      repeat ($urandom_range(0, 30)) cycle();
    end
    drain(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
